// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch program-counter generator.
// Holds the FSM state encodings and a small decode helper.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_RUN   = 2'd1,
    PC_FAULT = 2'd2
  } pc_state_e;

  // A fetch request exists only while running.
  function automatic logic state_fetches(input pc_state_e s);
    return (s == PC_RUN);
  endfunction

endpackage

// File: rtl/pc_gen_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Sticks at all-ones; meant for redirect and future performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with valid/ready handshake,
// branch/trap redirects, misaligned-branch fault and redirect counter.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc,
  output logic              chip_enable,
  output logic              pc_valid,
  input  logic              pc_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_target,
  output logic              misalign,
  output logic [CNT_W-1:0]  redirect_cnt
);

  // STEP is a power of two, so alignment is a low-bit mask test.
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);

  pc_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              chip_enable_reg, chip_enable_next;
  logic              misalign_reg, misalign_next;
  logic              redirect_inc;
  logic              br_aligned;

  assign br_aligned = ((br_target & STEP_MASK) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= PC_IDLE;
      pc_reg          <= RESET_VEC;
      chip_enable_reg <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      chip_enable_reg <= chip_enable_next;
      misalign_reg    <= misalign_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    chip_enable_next = chip_enable_reg;
    misalign_next    = 1'b0;
    redirect_inc     = 1'b0;
    case (state_reg)
      PC_IDLE: begin
        chip_enable_next = 1'b1;
        state_next       = PC_RUN;
      end
      PC_RUN: begin
        // Redirects drop the in-flight pc regardless of pc_ready.
        if (trap_valid) begin
          pc_next      = trap_target;
          redirect_inc = 1'b1;
        end else if (br_valid) begin
          if (br_aligned) begin
            pc_next      = br_target;
            redirect_inc = 1'b1;
          end else begin
            misalign_next = 1'b1;
            state_next    = PC_FAULT;
          end
        end else if (pc_ready) begin
          pc_next = pc_reg + STEP_INC;
        end
      end
      PC_FAULT: begin
        if (trap_valid) begin
          pc_next      = trap_target;
          redirect_inc = 1'b1;
          state_next   = PC_RUN;
        end
      end
      default: begin
        state_next = PC_IDLE;
      end
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_redirect_cnt (
    .clk(clk),
    .rst(rst),
    .inc(redirect_inc),
    .cnt(redirect_cnt)
  );

  assign pc          = pc_reg;
  assign chip_enable = chip_enable_reg;
  assign misalign    = misalign_reg;
  assign pc_valid    = state_fetches(state_reg);

endmodule
